// File: rtl/spatz_simd_seq.sv
// spatz_simd_seq: element sequencer feeding NrLanes spatz_simd lanes per beat.
// Latches one instruction (op, vl), streams operand beats onto the lane bus,
// captures lane results into a single-entry output register with strobes.
// Optional macro SPATZ_SIMD_SEQ_PERF_EN adds saturating beat/stall counters.

package spatz_simd_seq_pkg;
    typedef enum logic [3:0] {
        VADD  = 4'd0,
        VSUB  = 4'd1,
        VADC  = 4'd2,
        VSBC  = 4'd3,
        VMADC = 4'd4,
        VMSBC = 4'd5,
        VMUL  = 4'd6,
        VMACC = 4'd7,
        VAND  = 4'd8,
        VOR   = 4'd9,
        VXOR  = 4'd10
    } op_e;
endpackage

module spatz_simd_seq
    import spatz_simd_seq_pkg::*;
#(
    parameter int unsigned Width   = 8,
    parameter int unsigned NrLanes = 4,
    parameter int unsigned MaxVl   = 64,
    localparam int unsigned VlW    = $clog2(MaxVl) + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    // instruction handshake
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  op_e                        req_op_i,
    input  logic [VlW-1:0]             req_vl_i,
    // operand beats
    input  logic                       opnd_valid_i,
    output logic                       opnd_ready_o,
    input  logic [NrLanes*Width-1:0]   opnd_s1_i,
    input  logic [NrLanes*Width-1:0]   opnd_s2_i,
    input  logic [NrLanes*Width-1:0]   opnd_d_i,
    input  logic [NrLanes-1:0]         opnd_carry_i,
    // lane bus
    output op_e                        lane_op_o,
    output logic [NrLanes*Width-1:0]   lane_s1_o,
    output logic [NrLanes*Width-1:0]   lane_s2_o,
    output logic [NrLanes*Width-1:0]   lane_d_o,
    output logic [NrLanes-1:0]         lane_carry_o,
    input  logic [NrLanes*Width-1:0]   lane_result_i,
    // result stream
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [NrLanes*Width-1:0]   res_data_o,
    output logic [NrLanes-1:0]         res_strb_o,
    output logic                       res_last_o,
`ifdef SPATZ_SIMD_SEQ_PERF_EN
    output logic [31:0]                perf_beats_o,
    output logic [31:0]                perf_stall_o,
`endif
    output logic                       busy_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e           state_q;
    op_e              op_q;
    logic [VlW-1:0]   vl_q;
    logic [VlW-1:0]   cnt_q;
    logic [VlW-1:0]   remaining;
    logic [VlW-1:0]   vl_clamped;
    logic [NrLanes-1:0] strb_next;
    logic             accept;
    logic             pop;
    logic             last_beat;
    logic             carry_en;

    assign remaining    = vl_q - cnt_q;
    assign last_beat    = remaining <= VlW'(NrLanes);
    assign vl_clamped   = (req_vl_i > VlW'(MaxVl)) ? VlW'(MaxVl) : req_vl_i;
    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign opnd_ready_o = (state_q == RUN) && (!res_valid_o || res_ready_i);
    assign accept       = opnd_valid_i && opnd_ready_o;
    assign pop          = res_valid_o && res_ready_i;

    assign carry_en     = (op_q == VADC) || (op_q == VSBC) ||
                          (op_q == VMADC) || (op_q == VMSBC);
    assign lane_op_o    = op_q;
    assign lane_s1_o    = opnd_s1_i;
    assign lane_s2_o    = opnd_s2_i;
    assign lane_d_o     = opnd_d_i;
    assign lane_carry_o = carry_en ? opnd_carry_i : '0;

    // Strobe for the beat being accepted: lanes below the remaining count.
    always_comb begin
        strb_next = '0;
        for (int unsigned i = 0; i < NrLanes; i++) begin
            strb_next[i] = (i < 32'(remaining));
        end
    end

    // Sequencer FSM, element counter and single-entry result register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            op_q        <= VADD;
            vl_q        <= '0;
            cnt_q       <= '0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_strb_o  <= '0;
            res_last_o  <= 1'b0;
        end else begin
            // A pop and an accept on the same edge reload without a bubble.
            if (pop) begin
                res_valid_o <= 1'b0;
            end
            if (accept) begin
                res_valid_o <= 1'b1;
                res_data_o  <= lane_result_i;
                res_strb_o  <= strb_next;
                res_last_o  <= last_beat;
                cnt_q       <= cnt_q + VlW'(NrLanes);
            end
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        op_q  <= req_op_i;
                        vl_q  <= vl_clamped;
                        cnt_q <= '0;
                        if (vl_clamped != '0) begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept && last_beat) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPATZ_SIMD_SEQ_PERF_EN
    // Saturating counters of accepted beats and operand-side stalls in RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_beats_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (accept && (perf_beats_o != '1)) begin
                perf_beats_o <= perf_beats_o + 32'd1;
            end
            if ((state_q == RUN) && opnd_valid_i && !opnd_ready_o &&
                (perf_stall_o != '1)) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule
